// File: rtl/fpu_pkg.sv
// Shared FPU definitions: result format encodings, flag positions
// and the writeback formatting helpers used by converter and writeback.
package fpu_pkg;

   typedef enum logic [1:0] {
      FMT_FP32   = 2'b00,
      FMT_FP64   = 2'b01,
      FMT_INT32  = 2'b10,
      FMT_UINT32 = 2'b11
   } fmt_e;

   // fflags bit positions
   localparam int FL_NV = 4;
   localparam int FL_DZ = 3;
   localparam int FL_OF = 2;
   localparam int FL_UF = 1;
   localparam int FL_NX = 0;

   // converter flag bit positions
   localparam int CF_NV = 3;
   localparam int CF_OF = 2;
   localparam int CF_UF = 1;
   localparam int CF_NX = 0;

   function automatic logic is_fp_fmt(input logic [1:0] t);
      return (t == FMT_FP32) || (t == FMT_FP64);
   endfunction

   // UINT32 is sign-extended too, matching RV64 W-result convention.
   function automatic logic [63:0] fmt_result(
      input logic [63:0] r,
      input logic [1:0]  t
   );
      logic [63:0] d;
      d = r;
      unique case (fmt_e'(t))
         FMT_FP32:   d = {32'hFFFF_FFFF, r[31:0]};
         FMT_FP64:   d = r;
         FMT_INT32,
         FMT_UINT32: d = {{32{r[31]}}, r[31:0]};
         default:    d = r;
      endcase
      return d;
   endfunction

   function automatic logic [4:0] map_flags(input logic [3:0] f);
      logic [4:0] m;
      m        = '0;
      m[FL_NV] = f[CF_NV];
      m[FL_OF] = f[CF_OF];
      m[FL_UF] = f[CF_UF];
      m[FL_NX] = f[CF_NX];
      return m;
   endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Registered-output synchronous FIFO; head visible the cycle after
// its push, storage cleared on reset.
module fpu_sync_fifo
   import fpu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];

   // Power-of-two depth: pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + 1'b1;
         end
         if (do_pop) rptr <= rptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fp_cvt_writeback.sv
// Converter writeback stage: formats results at enqueue, buffers them,
// and accumulates sticky fflags as entries retire.
module fp_cvt_writeback
   import fpu_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_result,
   input  logic [1:0]       in_output_type,
   input  logic [TAG_W-1:0] in_tag,
   input  logic [3:0]       in_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_is_fp,
   output logic [4:0]       fflags,
   input  logic             fflags_we,
   input  logic [4:0]       fflags_wdata
);

   localparam int W = 64 + TAG_W + 1 + 4;

   logic [W-1:0] wr_entry;
   logic [W-1:0] rd_entry;
   logic [3:0]   head_flags;
   logic [4:0]   ret_flags;
   logic         full;
   logic         empty;
   logic         push;
   logic         pop;

   assign wr_entry = {
      fmt_result(in_result, in_output_type),
      in_tag,
      is_fp_fmt(in_output_type),
      in_flags
   };

   assign {out_data, out_tag, out_is_fp, head_flags} = rd_entry;

   // Gated by rst_n so the producer sees not-ready during reset.
   assign in_ready  = rst_n && !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   fpu_sync_fifo #(
      .WIDTH (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (rd_entry),
      .full  (full),
      .empty (empty)
   );

   assign ret_flags = pop ? map_flags(head_flags) : 5'b0;

   // A software write still keeps flags from an entry retiring this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fflags <= '0;
      end else if (fflags_we) begin
         fflags <= fflags_wdata | ret_flags;
      end else begin
         fflags <= fflags | ret_flags;
      end
   end

endmodule

// File: tb/tb_fp_cvt_writeback.sv
// Scoreboard bench for fp_cvt_writeback: directed cases plus random
// traffic checked against a queue-based reference model.
module tb_fp_cvt_writeback;

   localparam int DEPTH = 2;
   localparam int TAG_W = 5;

   typedef struct {
      logic [63:0] data;
      logic [4:0]  tag;
      logic        is_fp;
      logic [4:0]  fl;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_result = '0;
   logic [1:0]  in_output_type = '0;
   logic [4:0]  in_tag = '0;
   logic [3:0]  in_flags = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_data;
   logic [4:0]  out_tag;
   logic        out_is_fp;
   logic [4:0]  fflags;
   logic        fflags_we = 1'b0;
   logic [4:0]  fflags_wdata = '0;

   exp_t q[$];
   int   m_cnt = 0;
   logic [4:0] m_ff = '0;
   bit   in_reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   fp_cvt_writeback #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_result      (in_result),
      .in_output_type (in_output_type),
      .in_tag         (in_tag),
      .in_flags       (in_flags),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_tag        (out_tag),
      .out_is_fp      (out_is_fp),
      .fflags         (fflags),
      .fflags_we      (fflags_we),
      .fflags_wdata   (fflags_wdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [63:0] r, input logic [1:0] t,
                                  input logic [4:0] tag, input logic [3:0] f);
      exp_t e;
      longint s;
      s = longint'($signed(r[31:0]));
      case (t)
         2'd0:    e.data = {32'hFFFF_FFFF, r[31:0]};
         2'd1:    e.data = r;
         default: e.data = 64'(s);
      endcase
      e.is_fp = (t < 2);
      e.tag   = tag;
      e.fl    = {f[3], 1'b0, f[2], f[1], f[0]};
      return e;
   endfunction

   // Monitor: compares DUT against the model state, pops on retire.
   always @(negedge clk) begin
      if (!in_reset) begin
         logic [4:0] rf;
         bit ret;
         rf  = '0;
         ret = (m_cnt > 0) && out_ready;
         check("in_ready", 64'(in_ready), 64'(m_cnt < DEPTH));
         check("out_valid", 64'(out_valid), 64'(m_cnt > 0));
         check("fflags", 64'(fflags), 64'(m_ff));
         if (ret) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL scoreboard: retire with empty queue");
            end else begin
               exp_t e;
               e = q.pop_front();
               check("out_data", out_data, e.data);
               check("out_tag", 64'(out_tag), 64'(e.tag));
               check("out_is_fp", 64'(out_is_fp), 64'(e.is_fp));
               rf = e.fl;
            end
         end
         m_ff  = (fflags_we ? fflags_wdata : m_ff) | rf;
         m_cnt = m_cnt + int'(in_valid && m_cnt < DEPTH) - int'(ret);
      end
   end

   task automatic drive(input logic [63:0] r, input logic [1:0] t,
                        input logic [4:0] tag, input logic [3:0] f);
      in_valid       = 1'b1;
      in_result      = r;
      in_output_type = t;
      in_tag         = tag;
      in_flags       = f;
   endtask

   // Caller is at posedge+1; returns at posedge+1 after acceptance.
   task automatic send(input logic [63:0] r, input logic [1:0] t,
                       input logic [4:0] tag, input logic [3:0] f);
      bit done;
      done = 1'b0;
      drive(r, t, tag, f);
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back(model(r, t, tag, f));
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: in_ready stuck 0, expected 1");
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_reset = 1'b1;
      rst_n    = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_fflags", 64'(fflags), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      check("rst_out_is_fp", 64'(out_is_fp), 64'd0);
      q.delete();
      m_cnt     = 0;
      m_ff      = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      fflags_we = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", 64'(in_ready), 64'd1);
      check("rel_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      in_reset = 1'b0;
   endtask

   initial begin
      #2;
      do_reset();

      // INT32 negative with NV flag
      out_ready = 1'b1;
      send(64'h0000_0000_8000_0000, 2'b10, 5'd1, 4'b1000);
      idle(3);
      check("int32_fflags", 64'(fflags), 64'h10);

      // FP32 NaN-box, no flags
      send(64'h0000_0000_3F80_0000, 2'b00, 5'd2, 4'b0000);
      idle(3);
      check("fp32_fflags", 64'(fflags), 64'h10);

      // Fill with consumer stalled, then drain in order
      out_ready = 1'b0;
      send(64'h1234_5678_9ABC_DEF0, 2'b01, 5'd3, 4'b0000);
      send(64'h0000_0000_FFFF_FFFF, 2'b11, 5'd4, 4'b0000);
      drive(64'h0000_0000_0000_0007, 2'b10, 5'd5, 4'b0000);
      @(negedge clk);
      check("full_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(64'h0000_0000_0000_0007, 2'b10, 5'd5, 4'b0000);
      idle(4);

      // Software write coinciding with a retire
      out_ready = 1'b0;
      send(64'h0000_0000_4000_0000, 2'b00, 5'd6, 4'b0001);
      out_ready    = 1'b1;
      fflags_we    = 1'b1;
      fflags_wdata = 5'b00000;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      fflags_we = 1'b0;
      check("we_retire_fflags", 64'(fflags), 64'h01);
      fflags_we    = 1'b1;
      fflags_wdata = 5'b01000;
      @(posedge clk);
      #1;
      fflags_we = 1'b0;
      check("we_dz_fflags", 64'(fflags), 64'h08);

      // Reset with entries held
      send(64'h0000_0000_0000_0011, 2'b10, 5'd7, 4'b0100);
      send(64'h0000_0000_0000_0022, 2'b10, 5'd8, 4'b0010);
      do_reset();
      out_ready = 1'b1;
      idle(4);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [63:0] r;
         logic [1:0]  t;
         logic [4:0]  tg;
         logic [3:0]  f;
         r  = {$urandom, $urandom};
         t  = 2'($urandom_range(0, 3));
         tg = 5'($urandom);
         f  = 4'($urandom);
         in_valid       = ($urandom_range(0, 2) != 0);
         in_result      = r;
         in_output_type = t;
         in_tag         = tg;
         in_flags       = f;
         out_ready      = ($urandom_range(0, 2) != 0);
         fflags_we      = ($urandom_range(0, 15) == 0);
         fflags_wdata   = 5'($urandom);
         @(negedge clk);
         if (in_valid && in_ready) q.push_back(model(r, t, tg, f));
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      fflags_we = 1'b0;
      out_ready = 1'b1;
      idle(8);
      check("drain_queue", 64'(q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fp_cvt_writeback.md
FP_CVT_WRITEBACK -- requirements
Module: fp_cvt_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning output buffer entries (power of two, 2..8).
REQ-002 SHALL have parameter TAG_W, default 5, meaning destination-register tag width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  converter result present.
REQ-006 SHALL have port in_ready  output  1  buffer can accept (not full).
REQ-007 SHALL have port in_result  input  64  raw converter result.
REQ-008 SHALL have port in_output_type  input  2  00 FP32, 01 FP64, 10 INT32, 11 UINT32.
REQ-009 SHALL have port in_tag  input  TAG_W  destination tag.
REQ-010 SHALL have port in_flags  input  4  {invalid, overflow, underflow, inexact}.
REQ-011 SHALL have port out_valid  output  1  head entry present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head.
REQ-013 SHALL have port out_data  output  64  formatted writeback data.
REQ-014 SHALL have port out_tag  output  TAG_W  head tag.
REQ-015 SHALL have port out_is_fp  output  1  head targets FP register file.
REQ-016 SHALL have port fflags  output  5  sticky {NV,DZ,OF,UF,NX}.
REQ-017 SHALL have port fflags_we  input  1  software write of fflags.
REQ-018 SHALL have port fflags_wdata  input  5  software write value.

Function
REQ-019 SHALL accept an entry when in_valid && in_ready; SHALL retire head when out_valid && out_ready.
REQ-020 SHALL format at enqueue: INT32/UINT32 -> in_result[31:0] sign-extended to 64 bits (UINT32 0xFFFFFFFF -> 0xFFFFFFFFFFFFFFFF); FP64 -> unchanged; FP32 -> {32'hFFFFFFFF, in_result[31:0]} (NaN-boxed).
REQ-021 SHALL set out_is_fp = 1 for FP32/FP64 types, 0 for integer types.
REQ-022 SHALL present accepted data at out_* the cycle after acceptance (1-cycle latency), no combinational in->out path.
REQ-023 SHALL keep in_ready = (count < DEPTH), independent of out_ready (no bypass when full).
REQ-024 SHALL on simultaneous enqueue and retire keep count unchanged; when full and retiring, in_ready stays 0 that cycle.
REQ-025 SHALL hold out_data/out_tag/out_is_fp stable while out_valid && !out_ready.
REQ-026 SHALL wrap read/write pointers modulo DEPTH; count 0..DEPTH.
REQ-027 SHALL map stored flags to 5-bit {NV,0,OF,UF,NX}; DZ never raised by this block.
REQ-028 SHALL OR a retiring entry's flags into fflags on the retire edge, not at enqueue.
REQ-029 SHALL on fflags_we load fflags <= fflags_wdata | retiring flags (same-cycle retire not lost).
REQ-030 SHALL accept fflags_wdata reaching bit DZ (software may set DZ).

Reset
REQ-031 SHALL on rst_n low immediately clear count, pointers, fflags; out_valid=0, in_ready=0 while asserted, in_ready=1 first cycle after release.
REQ-032 SHALL drop in-flight entries on reset mid-operation; out_data/out_tag/out_is_fp reset to 0.

Structure
REQ-033 SHALL take FP type encodings (FP32/FP64/INT32/UINT32) and flag bit positions from a shared package fpu_pkg used also by the converter.
REQ-034 SHALL implement storage as one sub-module fpu_sync_fifo (parameterised width/depth); formatting and fflags logic stay in the top.

Verification
REQ-035 SHALL cover: INT32 result 0x0000000080000000, flags 1000, retire -> out_data 0xFFFFFFFF80000000, out_is_fp 0, fflags 10000.
REQ-036 SHALL cover: FP32 result 0x3F800000 -> out_data 0xFFFFFFFF3F800000, out_is_fp 1, fflags unchanged.
REQ-037 SHALL cover: out_ready=0, enqueue 3 entries -> in_ready 0 after 2nd; release out_ready -> entries retire in order, tags preserved.
REQ-038 SHALL cover: fflags_we wdata 00000 same cycle as retire with flags 0001 -> fflags 00001.
REQ-039 SHALL cover: rst_n low with 2 entries held -> out_valid 0 asynchronously, fflags 0, no entry emitted after release.
